apb4_wait_ram: RTL and testbench
================================

# apb4_wait_ram

APB4 completer wrapping a parametrised, byte-lane-strobed RAM, with configurable wait states and full PSLVERR reporting for address, protection and strobe violations. Next-generation successor to the current APB slave memory:
- true per-byte strobe merge, with no sign extension or lane zeroing
- word-aligned addressing
- bounded address decode
- optional privileged-write enforcement

Sits behind the APB interconnect as a single-select target and is the DUT of the APB RAM UVM environment.

## Interface
Parameters:
- DATA_WIDTH, 32: PWDATA/PRDATA width; must be 8, 16, 32 or 64.
- ADDR_WIDTH, 32: PADDR width.
- MEM_DEPTH, 256: number of DATA_WIDTH words.
- WAIT_STATES, 0: PREADY-low cycles inserted per transfer; range 0..15.
- PROT_CHECK, 0: 1 rejects unprivileged writes (PPROT[0]==0).

Ports:
- PCLK  input  1  single clock; all logic on rising edge.
- PRESET  input  1  reset; synchronous, active-high.
- PSEL  input  1  slave select.
- PENABLE  input  1  access phase.
- PWRITE  input  1  1 = write, 0 = read.
- PADDR  input  ADDR_WIDTH  byte address.
- PWDATA  input  DATA_WIDTH  write data.
- PSTRB  input  DATA_WIDTH/8  byte-lane write strobes.
- PPROT  input  3  protection attributes.
- PRDATA  output  DATA_WIDTH  read data; registered.
- PREADY  output  1  transfer completion.
- PSLVERR  output  1  transfer error; qualified by PREADY.

## Operation
- Constants:
  - LSB = log2(DATA_WIDTH/8).
  - Word index = PADDR[LSB +: clog2(MEM_DEPTH)].
- FSM states:
  - IDLE → ACCESS when PSEL=1 && PENABLE=0 (setup cycle).
  - ACCESS → IDLE on the completion cycle.
  - ACCESS → IDLE (abort) if PSEL or PENABLE drops before completion.
- At the setup edge:
  - Wait counter loads WAIT_STATES.
  - Error flag err_q is latched. err_q=1 if any of:
    - PADDR[LSB-1:0] != 0 (unaligned)
    - PADDR >> LSB >= MEM_DEPTH (out of range)
    - read with PSTRB != 0
    - PROT_CHECK=1 && write && PPROT[0]==0
  - For an error-free read, PRDATA <= mem[index]. For an errored read, PRDATA <= 0.
- In ACCESS: counter decrements each cycle while nonzero. Completion cycle is ACCESS with counter==0.
- Write commit, at the completion edge, only if err_q=0:
  - Lane i updated iff PSTRB[i]; other lanes keep their old value.
  - PSTRB=0 write is legal: no change, no error.
- Errored write: memory untouched.
- Abort: no memory update; PRDATA retains its value; PREADY/PSLVERR never asserted.
- Reset: state IDLE, counter 0, PRDATA 0, PREADY 0, PSLVERR 0. Memory contents are not cleared.
  - A reset during ACCESS cancels the transfer; a pending write does not commit.
- Address, data, strobe and PPROT are sampled only at the setup edge. Changes during ACCESS are ignored.

## Timing
- PREADY = (state==ACCESS) && (counter==0). Combinational from registers, no input paths.
- PSLVERR = PREADY && err_q. It is 0 in every non-completion cycle.
- Transfer length is 2 + WAIT_STATES cycles, from setup to completion inclusive.
- PRDATA is valid from the first ACCESS cycle and holds until the next read setup.
- Back-to-back transfers: the next setup may occur in the cycle after completion, with no extra idle cycle.
- A read immediately after a write to the same word returns the new data, because the write commits before the next setup edge.

## Structure
- Shared package apb_pkg holds:
  - state enum {IDLE, ACCESS}
  - error-cause constants (ERR_ALIGN, ERR_RANGE, ERR_STRB, ERR_PROT) for coverage
  - default parameter values
- Sub-module apb_bytewise_ram: single-port array, DATA_WIDTH/8 byte enables, synchronous write, read registered on an enable strobe.
- Top level holds the FSM, wait counter, decode/error logic and output gating.

## Test plan
- Reset, WAIT_STATES=0: write 0xDEADBEEF to 0x10 with PSTRB=4'hF, then read 0x10.
  - Each transfer takes 2 cycles.
  - PRDATA=0xDEADBEEF, PSLVERR=0.
- Partial strobe: preload 0x11223344 at 0x20, write 0xAABBCCDD with PSTRB=4'b0101, read 0x20.
  - Read returns 0x11BB33DD.
- WAIT_STATES=3: any transfer holds PREADY=0 for 3 ACCESS cycles and completes in cycle 5.
  - Insert PSEL drop mid-wait: no write, no PREADY.
- Error cases (MEM_DEPTH=256): each gives PSLVERR=1 on the completion cycle and leaves memory unchanged; the read case also returns PRDATA=0.
  - Write to 0x400 (out of range)
  - Write to 0x13 (unaligned)
  - Read with PSTRB=4'h1
- PROT_CHECK=1: write with PPROT=3'b000 → PSLVERR=1, no update. Same write with PPROT=3'b001 → PSLVERR=0, data stored.
- PRESET asserted in the ACCESS cycle of a write of 0x5A5A5A5A to 0x30.
  - Outputs go 0 and the word keeps its prior value.
  - The next transfer completes normally.

Source files
------------

// File: rtl/apb_pkg.sv
// Shared definitions for the APB4 wait-state RAM: FSM states, error-cause bit
// positions and default parameter values.
package apb_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } apb_state_e;

    // Bit positions inside the latched error-cause vector
    localparam int ERR_ALIGN = 0;
    localparam int ERR_RANGE = 1;
    localparam int ERR_STRB  = 2;
    localparam int ERR_PROT  = 3;
    localparam int ERR_NUM   = 4;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_ADDR_WIDTH  = 32;
    localparam int DEF_MEM_DEPTH   = 256;
    localparam int DEF_WAIT_STATES = 0;
    localparam int DEF_PROT_CHECK  = 0;

    // Word-index width; a one-word memory still needs a 1-bit index
    function automatic int idx_bits(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/apb_bytewise_ram.sv
// Single-port word RAM with per-byte write enables and a registered read
// that can be forced to zero for rejected reads.
module apb_bytewise_ram
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int MEM_DEPTH  = DEF_MEM_DEPTH,
    parameter int IDX_W      = idx_bits(DEF_MEM_DEPTH)
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [IDX_W-1:0]        i_addr,
    input  logic [DATA_WIDTH/8-1:0] i_be,
    input  logic [DATA_WIDTH-1:0]   i_wdata,
    input  logic                    i_rd_en,
    input  logic                    i_rd_zero,
    output logic [DATA_WIDTH-1:0]   o_rdata
);
    localparam int NB = DATA_WIDTH / 8;

    logic [DATA_WIDTH-1:0] r_mem [MEM_DEPTH];
    logic [DATA_WIDTH-1:0] r_rdata;

    // Byte-lane write; lanes without an enable keep their stored value
    always_ff @(posedge i_clk) begin
        for (int b = 0; b < NB; b++) begin
            if (i_be[b]) begin
                r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
            end
        end
    end

    // Read register: loads the addressed word (or zero) only when strobed
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_rdata <= '0;
        end else if (i_rd_en) begin
            r_rdata <= i_rd_zero ? '0 : r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/apb4_wait_ram.sv
// APB4 completer around a byte-strobed RAM: setup-edge sampling and decode,
// programmable wait states, and PSLVERR for alignment/range/strobe/prot faults.
module apb4_wait_ram
    import apb_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int MEM_DEPTH   = DEF_MEM_DEPTH,
    parameter int WAIT_STATES = DEF_WAIT_STATES,
    parameter int PROT_CHECK  = DEF_PROT_CHECK
) (
    input  logic                    PCLK,
    input  logic                    PRESET,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic                    PWRITE,
    input  logic [ADDR_WIDTH-1:0]   PADDR,
    input  logic [DATA_WIDTH-1:0]   PWDATA,
    input  logic [DATA_WIDTH/8-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    output logic [DATA_WIDTH-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR
);
    localparam int NB    = DATA_WIDTH / 8;
    localparam int LSB   = $clog2(NB);
    localparam int IDX_W = idx_bits(MEM_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ADDR_WIDTH'((1 << LSB) - 1);
    localparam logic [ADDR_WIDTH-1:0] DEPTH_A    = ADDR_WIDTH'(MEM_DEPTH);
    localparam logic [3:0]            WAIT_INIT  = 4'(WAIT_STATES);

    apb_state_e            r_state;
    apb_state_e            w_state_nxt;
    logic [3:0]            r_cnt;
    logic                  r_write;
    logic [ERR_NUM-1:0]    r_err_cause;
    logic [NB-1:0]         r_strb;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [IDX_W-1:0]      r_idx;

    logic                  w_setup;
    logic                  w_ready;
    logic                  w_err;
    logic                  w_commit;
    logic [ADDR_WIDTH-1:0] w_word;
    logic [IDX_W-1:0]      w_idx;
    logic [ERR_NUM-1:0]    w_err_cause;
    logic [IDX_W-1:0]      w_ram_addr;
    logic [NB-1:0]         w_ram_be;
    logic                  w_unused_prot;

    // Setup-phase decode: word index and every reason to reject the transfer
    assign w_setup = (r_state == ST_IDLE) && PSEL && !PENABLE;
    assign w_word  = PADDR >> LSB;
    assign w_idx   = w_word[IDX_W-1:0];

    assign w_err_cause[ERR_ALIGN] = |(PADDR & ALIGN_MASK);
    assign w_err_cause[ERR_RANGE] = (w_word >= DEPTH_A);
    assign w_err_cause[ERR_STRB]  = !PWRITE && (PSTRB != '0);
    assign w_err_cause[ERR_PROT]  = (PROT_CHECK != 0) && PWRITE && !PPROT[0];

    // Only PPROT[0] (privileged) matters to this target
    assign w_unused_prot = ^PPROT[2:1];

    // Completion and error gating come purely from registered state
    assign w_ready = (r_state == ST_ACCESS) && (r_cnt == 4'd0);
    assign w_err   = |r_err_cause;
    assign PREADY  = w_ready;
    assign PSLVERR = w_ready && w_err;

    // A reset landing on the completion edge must not let the write through
    assign w_commit   = w_ready && r_write && !w_err && !PRESET;
    assign w_ram_be   = w_commit ? r_strb : '0;
    assign w_ram_addr = w_setup ? w_idx : r_idx;

    // FSM state register
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM next state: leave ACCESS on completion or when the requester backs off
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (PSEL && !PENABLE) begin
                    w_state_nxt = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if ((r_cnt == 4'd0) || !PSEL || !PENABLE) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Wait counter: loaded at setup, counts down to the completion cycle
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_cnt <= 4'd0;
        end else if (w_setup) begin
            r_cnt <= WAIT_INIT;
        end else if ((r_state == ST_ACCESS) && (r_cnt != 4'd0)) begin
            r_cnt <= r_cnt - 4'd1;
        end
    end

    // Control capture at the setup edge: direction and error causes
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_write     <= 1'b0;
            r_err_cause <= '0;
        end else if (w_setup) begin
            r_write     <= PWRITE;
            r_err_cause <= w_err_cause;
        end
    end

    // Data capture at the setup edge; later bus changes are ignored
    always_ff @(posedge PCLK) begin
        if (w_setup) begin
            r_strb  <= PSTRB;
            r_wdata <= PWDATA;
            r_idx   <= w_idx;
        end
    end

    apb_bytewise_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .MEM_DEPTH  (MEM_DEPTH),
        .IDX_W      (IDX_W)
    ) u_ram (
        .i_clk     (PCLK),
        .i_rst     (PRESET),
        .i_addr    (w_ram_addr),
        .i_be      (w_ram_be),
        .i_wdata   (r_wdata),
        .i_rd_en   (w_setup && !PWRITE),
        .i_rd_zero (|w_err_cause),
        .o_rdata   (PRDATA)
    );

endmodule

// File: tb/tb_apb4_wait_ram.sv
// Bench for apb4_wait_ram: one zero-wait instance and one 3-wait,
// privilege-checking instance on a shared bus with separate selects.
module tb_apb4_wait_ram;

    localparam int WS0 = 0;
    localparam int WS1 = 3;

    logic        PCLK = 1'b0;
    logic        PRESET;
    logic        psel0, psel1;
    logic        PENABLE, PWRITE;
    logic [31:0] PADDR, PWDATA;
    logic [3:0]  PSTRB;
    logic [2:0]  PPROT;
    logic [31:0] prdata0, prdata1;
    logic        pready0, pready1, pslverr0, pslverr1;

    always #5 PCLK = ~PCLK;

    apb4_wait_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(256),
                    .WAIT_STATES(WS0), .PROT_CHECK(0)) u_dut0 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel0), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PPROT(PPROT), .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0));

    apb4_wait_ram #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .MEM_DEPTH(256),
                    .WAIT_STATES(WS1), .PROT_CHECK(1)) u_dut1 (
        .PCLK(PCLK), .PRESET(PRESET), .PSEL(psel1), .PENABLE(PENABLE),
        .PWRITE(PWRITE), .PADDR(PADDR), .PWDATA(PWDATA), .PSTRB(PSTRB),
        .PPROT(PPROT), .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1));

    typedef struct {
        string       tag;
        logic [31:0] rdata;
        bit          is_rd;
        bit          err;
        int          cycles;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] mdl [2][256];
    logic [31:0] last_rd [2];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, expv);
        end
    endtask

    function automatic logic rdy(input int d);
        return (d == 0) ? pready0 : pready1;
    endfunction

    function automatic logic serr(input int d);
        return (d == 0) ? pslverr0 : pslverr1;
    endfunction

    function automatic logic [31:0] rdat(input int d);
        return (d == 0) ? prdata0 : prdata1;
    endfunction

    task automatic idle();
        @(posedge PCLK); #1;
        psel0 = 1'b0; psel1 = 1'b0; PENABLE = 1'b0;
    endtask

    // One complete transfer; the expectation is computed from the model and
    // queued at setup, then popped when the DUT signals completion.
    task automatic apb_xfer(input int d, input bit wr, input logic [31:0] addr,
                            input logic [31:0] wdata, input logic [3:0] strb,
                            input logic [2:0] prot, input string tag);
        exp_t        e, got;
        logic [31:0] idx;
        bit          err, done;
        int          cyc;
        idx = addr >> 2;
        err = (addr[1:0] != 2'b00) || (idx >= 32'd256) || (!wr && strb != 4'h0) ||
              (d == 1 && wr && !prot[0]);
        e.tag    = tag;
        e.err    = err;
        e.is_rd  = !wr;
        e.cycles = 2 + ((d == 0) ? WS0 : WS1);
        e.rdata  = err ? 32'h0 : mdl[d][idx[7:0]];
        sb.push_back(e);
        if (wr && !err) begin
            for (int b = 0; b < 4; b++) begin
                if (strb[b]) mdl[d][idx[7:0]][8*b +: 8] = wdata[8*b +: 8];
            end
        end
        @(posedge PCLK); #1;
        psel0 = (d == 0); psel1 = (d == 1);
        PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        PSTRB = strb; PPROT = prot;
        cyc = 1;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        PADDR = addr ^ 32'h4; PWDATA = ~wdata; PSTRB = ~strb;
        cyc = 2;
        done = 1'b0;
        while (!done && cyc < 40) begin
            @(negedge PCLK);
            if (rdy(d)) begin
                done = 1'b1;
            end else begin
                chk({tag, "_err_early"}, serr(d), 0);
                @(posedge PCLK); #1;
                cyc++;
            end
        end
        got = sb.pop_front();
        chk({got.tag, "_cycles"}, cyc, got.cycles);
        if (done) begin
            chk({got.tag, "_slverr"}, serr(d), got.err);
            if (got.is_rd) begin
                chk({got.tag, "_rdata"}, rdat(d), got.rdata);
                last_rd[d] = rdat(d);
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        PRESET = 1'b1; psel0 = 1'b0; psel1 = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; PSTRB = '0; PPROT = '0;
        last_rd[0] = '0; last_rd[1] = '0;
        repeat (3) @(posedge PCLK);
        @(negedge PCLK);
        chk("rst_pready0", pready0, 0);
        chk("rst_pslverr0", pslverr0, 0);
        chk("rst_prdata0", prdata0, 0);
        chk("rst_pready1", pready1, 0);
        chk("rst_prdata1", prdata1, 0);
        @(posedge PCLK); #1;
        PRESET = 1'b0;

        // Basic write/read, back-to-back
        apb_xfer(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 3'b000, "wr_10");
        apb_xfer(0, 0, 32'h10, 32'h0, 4'h0, 3'b000, "rd_10");
        chk("rd_10_const", last_rd[0], 32'hDEADBEEF);

        // Partial strobe merge
        apb_xfer(0, 1, 32'h20, 32'h11223344, 4'hF, 3'b000, "pre_20");
        apb_xfer(0, 1, 32'h20, 32'hAABBCCDD, 4'b0101, 3'b000, "strb_20");
        apb_xfer(0, 0, 32'h20, 32'h0, 4'h0, 3'b000, "rd_20");
        chk("rd_20_const", last_rd[0], 32'h11BB33DD);

        // Error cases; memory must stay put
        apb_xfer(0, 1, 32'h400, 32'h01010101, 4'hF, 3'b000, "wr_oor");
        apb_xfer(0, 1, 32'h13, 32'h02020202, 4'hF, 3'b000, "wr_unal");
        apb_xfer(0, 0, 32'h10, 32'h0, 4'h1, 3'b000, "rd_strb");
        chk("rd_strb_zero", last_rd[0], 32'h0);
        apb_xfer(0, 1, 32'h10, 32'h03030303, 4'h0, 3'b000, "wr_nostrb");
        apb_xfer(0, 0, 32'h10, 32'h0, 4'h0, 3'b000, "rd_10_after");
        apb_xfer(0, 0, 32'h0, 32'h0, 4'h0, 3'b000, "rd_00_after");
        chk("rd_10_kept", u_dut0.u_ram.r_mem[4], 32'hDEADBEEF);

        // Wait states and privilege enforcement
        apb_xfer(1, 1, 32'h50, 32'hBAD0BAD0, 4'hF, 3'b000, "prot_user");
        apb_xfer(1, 1, 32'h50, 32'h600DCAFE, 4'hF, 3'b001, "prot_priv");
        apb_xfer(1, 0, 32'h50, 32'h0, 4'h0, 3'b000, "rd_50");
        chk("rd_50_const", last_rd[1], 32'h600DCAFE);
        apb_xfer(1, 0, 32'h404, 32'h0, 4'h0, 3'b001, "rd_oor_ws");
        apb_xfer(1, 1, 32'h40, 32'hCAFEF00D, 4'hF, 3'b001, "wr_40");
        apb_xfer(1, 0, 32'h40, 32'h0, 4'h0, 3'b001, "rd_40");

        // Abort mid-wait: no completion, no write, PRDATA held
        idle();
        @(posedge PCLK); #1;
        psel1 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h40;
        PWDATA = 32'h12345678; PSTRB = 4'hF; PPROT = 3'b001;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge PCLK);
            chk("abort_wait_pready", pready1, 0);
            @(posedge PCLK); #1;
        end
        psel1 = 1'b0; PENABLE = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge PCLK);
            chk("abort_pready", pready1, 0);
            chk("abort_pslverr", pslverr1, 0);
        end
        chk("abort_prdata", prdata1, last_rd[1]);
        apb_xfer(1, 0, 32'h40, 32'h0, 4'h0, 3'b001, "rd_40_abort");

        // Reset during the ACCESS cycle of a write
        apb_xfer(0, 1, 32'h30, 32'h01020304, 4'hF, 3'b000, "pre_30");
        apb_xfer(0, 0, 32'h30, 32'h0, 4'h0, 3'b000, "rd_30");
        idle();
        @(posedge PCLK); #1;
        psel0 = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h30;
        PWDATA = 32'h5A5A5A5A; PSTRB = 4'hF; PPROT = 3'b000;
        @(posedge PCLK); #1;
        PENABLE = 1'b1; PRESET = 1'b1;
        @(posedge PCLK); #1;
        PRESET = 1'b0; psel0 = 1'b0; PENABLE = 1'b0;
        @(negedge PCLK);
        chk("rstacc_pready", pready0, 0);
        chk("rstacc_pslverr", pslverr0, 0);
        chk("rstacc_prdata", prdata0, 0);
        apb_xfer(0, 0, 32'h30, 32'h0, 4'h0, 3'b000, "rd_30_rst");
        chk("rd_30_const", last_rd[0], 32'h01020304);

        // Randomised strobe merges against the model
        for (int i = 0; i < 12; i++) begin
            logic [31:0] a;
            a = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
            apb_xfer(0, 1, a, $urandom, 4'($urandom_range(0, 15)), 3'b000, "rnd_wr");
            apb_xfer(0, 0, a, 32'h0, 4'h0, 3'b000, "rnd_rd");
        end
        idle();
        repeat (2) @(posedge PCLK);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
